// File: rtl/uart_loader_pkg.sv
// Shared state encoding and protocol byte values for the UART instruction loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_ACK   = 3'd4,
      S_NAK   = 3'd5
   } state_t;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RST  = 8'h52;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;

endpackage

// File: rtl/uart_imem_loader_if.sv
// UART FIFO, instruction memory and CPU control signals seen by the loader.
interface uart_imem_loader_if #(
   parameter int NB_INSTRUCTION  = 32,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int NB_UART_DATA    = 9
);
   logic [NB_UART_DATA-1:0]    i_rx_data;
   logic                       i_rx_empty;
   logic                       o_rx_rd;
   logic                       i_tx_full;
   logic                       o_tx_wr;
   logic [NB_UART_DATA-1:0]    o_tx_wdata;
   logic                       o_tx_start;
   logic                       o_imem_we;
   logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
   logic [NB_INSTRUCTION-1:0]  o_imem_wdata;
   logic                       o_cpu_en;
   logic                       o_cpu_rst;

   // Loader side
   modport master (
      input  i_rx_data, i_rx_empty, i_tx_full,
      output o_rx_rd, o_tx_wr, o_tx_wdata, o_tx_start,
             o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst
   );

   // FIFO / memory / CPU side
   modport slave (
      output i_rx_data, i_rx_empty, i_tx_full,
      input  o_rx_rd, o_tx_wr, o_tx_wdata, o_tx_start,
             o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_en, o_cpu_rst
   );
endinterface

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word packer: first byte lands in [7:0], fourth in [31:24].
module loader_word_asm #(
   parameter int NB_INSTRUCTION = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      vld,
   input  logic [7:0]                din,
   output logic [NB_INSTRUCTION-1:0] word,
   output logic                      done
);
   logic [1:0]                byte_cnt;
   logic [NB_INSTRUCTION-1:0] shreg;

   // New byte shifts in from the top, so after four bytes the first sits at the bottom.
   assign word = {din, shreg[NB_INSTRUCTION-1:8]};
   assign done = vld && (byte_cnt == 2'd3);

   // Byte position and partial word; cleared on reset or at the start of a load.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_cnt <= '0;
         shreg    <= '0;
      end else if (vld) begin
         byte_cnt <= byte_cnt + 2'd1;
         shreg    <= word;
      end
   end
endmodule

// File: rtl/uart_imem_loader.sv
// Receives 'L' <count> <words...> over UART and writes them into instruction memory;
// 'R' pulses the CPU reset. Every command is answered with ACK or NAK on TX.
module uart_imem_loader
   import uart_loader_pkg::*;
#(
   parameter int NB_INSTRUCTION  = 32,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int NB_UART_DATA    = 9
) (
   input logic                clk,
   input logic                i_rst,
   uart_imem_loader_if.master bus
);
   state_t                     state, state_nx;
   logic [IMEM_ADDR_WIDTH-1:0] addr;
   logic [IMEM_ADDR_WIDTH:0]   words_left;
   logic [NB_INSTRUCTION-1:0]  wdata;
   logic                       cpu_en, cpu_rst, tx_start;
   logic                       rx_rd, tx_wr, asm_vld, asm_clr, word_done;
   logic [7:0]                 rx_byte, tx_byte;
   logic [NB_INSTRUCTION-1:0]  asm_word;
   logic                       unused_rx_hi;

   assign rx_byte      = bus.i_rx_data[7:0];
   assign unused_rx_hi = ^bus.i_rx_data[NB_UART_DATA-1:8];

   // Pop whenever a byte is available in the receiving states.
   assign rx_rd   = !i_rst && !bus.i_rx_empty &&
                    (state == S_IDLE || state == S_LEN || state == S_DATA);
   assign asm_vld = rx_rd && (state == S_DATA);
   assign asm_clr = (state == S_LEN);

   loader_word_asm #(.NB_INSTRUCTION(NB_INSTRUCTION)) u_word_asm (
      .clk  (clk),
      .rst  (i_rst),
      .clr  (asm_clr),
      .vld  (asm_vld),
      .din  (rx_byte),
      .word (asm_word),
      .done (word_done)
   );

   // Next-state decode and TX response.
   always_comb begin
      state_nx = state;
      tx_wr    = 1'b0;
      tx_byte  = 8'h00;
      unique case (state)
         S_IDLE: if (rx_rd) begin
            if (rx_byte == CMD_LOAD)     state_nx = S_LEN;
            else if (rx_byte == CMD_RST) state_nx = S_ACK;
            else                         state_nx = S_NAK;
         end
         S_LEN:   if (rx_rd) state_nx = S_DATA;
         S_DATA:  if (word_done) state_nx = S_WRITE;
         S_WRITE: state_nx = (words_left == (IMEM_ADDR_WIDTH+1)'(1)) ? S_ACK : S_DATA;
         S_ACK, S_NAK: begin
            tx_byte = (state == S_ACK) ? ACK : NAK;
            if (!bus.i_tx_full) begin
               tx_wr    = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (i_rst) begin
         tx_wr   = 1'b0;
         tx_byte = 8'h00;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Address, word count, write data and CPU control registers.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         addr       <= '0;
         words_left <= '0;
         wdata      <= '0;
         cpu_en     <= 1'b1;
         cpu_rst    <= 1'b0;
         tx_start   <= 1'b0;
      end else begin
         tx_start <= tx_wr;
         cpu_rst  <= rx_rd && (state == S_IDLE) && (rx_byte == CMD_RST);
         if (rx_rd && (state == S_IDLE) && (rx_byte == CMD_LOAD)) cpu_en <= 1'b0;
         if (tx_wr) cpu_en <= 1'b1;
         if (rx_rd && (state == S_LEN)) begin
            // A count of zero means a full memory image.
            words_left <= (rx_byte == 8'h00) ? {1'b1, {IMEM_ADDR_WIDTH{1'b0}}}
                                             : (IMEM_ADDR_WIDTH+1)'(rx_byte);
            addr       <= '0;
         end
         if (word_done) wdata <= asm_word;
         if (state == S_WRITE) begin
            addr       <= addr + 1'b1;
            words_left <= words_left - 1'b1;
         end
      end
   end

   assign bus.o_rx_rd      = rx_rd;
   assign bus.o_tx_wr      = tx_wr;
   assign bus.o_tx_wdata   = {{(NB_UART_DATA-8){1'b0}}, tx_byte};
   assign bus.o_tx_start   = tx_start;
   assign bus.o_imem_we    = !i_rst && (state == S_WRITE);
   assign bus.o_imem_addr  = addr;
   assign bus.o_imem_wdata = wdata;
   assign bus.o_cpu_en     = cpu_en;
   assign bus.o_cpu_rst    = cpu_rst;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed + randomized bench: a queue-backed RX FIFO feeds command streams, a monitor
// logs every DUT event with its cycle, and expectations come from parsing the stream.
module tb_uart_imem_loader;
   import uart_loader_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_imem_loader_if bif ();
   uart_imem_loader dut (.clk(clk), .i_rst(rst), .bus(bif));

   logic [8:0] rx_data_r  = '0;
   logic       rx_empty_r = 1'b1;
   logic       tx_full_r  = 1'b0;
   bit         stall_en   = 1'b0;
   bit         pend_pop   = 1'b0;
   assign bif.i_rx_data  = rx_data_r;
   assign bif.i_rx_empty = rx_empty_r;
   assign bif.i_tx_full  = tx_full_r;

   logic [7:0]  rxq[$];
   logic [7:0]  cmd[$];
   int          cyc = 0;
   logic [7:0]  rx_b[$];
   int          rx_c[$];
   logic [7:0]  w_a[$];
   logic [31:0] w_d[$];
   int          w_c[$];
   logic [8:0]  tx_b[$];
   int          tx_c[$];
   int          ts_c[$];
   int          rst_c[$];
   bit          en_log[0:19999];
   int          n_chk = 0;
   int          n_fail = 0;

   // RX FIFO model plus event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (pend_pop && rxq.size() > 0) rxq.delete(0);
      rx_empty_r = (rxq.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
      rx_data_r  = (rxq.size() > 0) ? {1'b0, rxq[0]} : 9'h000;
      #1;
      pend_pop = bif.o_rx_rd;
      if (bif.o_rx_rd)      begin rx_b.push_back(bif.i_rx_data[7:0]); rx_c.push_back(cyc); end
      if (bif.o_imem_we)    begin w_a.push_back(bif.o_imem_addr); w_d.push_back(bif.o_imem_wdata); w_c.push_back(cyc); end
      if (bif.o_tx_wr)      begin tx_b.push_back(bif.o_tx_wdata); tx_c.push_back(cyc); end
      if (bif.o_tx_start)   ts_c.push_back(cyc);
      if (bif.o_cpu_rst)    rst_c.push_back(cyc);
      if (cyc < 20000) en_log[cyc] = bif.o_cpu_en;
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rx_b.delete(); rx_c.delete(); w_a.delete(); w_d.delete(); w_c.delete();
      tx_b.delete(); tx_c.delete(); ts_c.delete(); rst_c.delete();
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_rx_rd"},    bif.o_rx_rd, 0);
      check({pfx, "_tx_wr"},    bif.o_tx_wr, 0);
      check({pfx, "_tx_start"}, bif.o_tx_start, 0);
      check({pfx, "_imem_we"},  bif.o_imem_we, 0);
      check({pfx, "_cpu_rst"},  bif.o_cpu_rst, 0);
      check({pfx, "_addr"},     bif.o_imem_addr, 0);
      check({pfx, "_wdata"},    bif.o_imem_wdata, 0);
      check({pfx, "_tx_wdata"}, bif.o_tx_wdata, 0);
      check({pfx, "_cpu_en"},   bif.o_cpu_en, 1);
   endtask

   // Feed cmd[] and compare the DUT's behaviour against the parsed command.
   task automatic run_cmd();
      logic [7:0]  ea[$];
      logic [31:0] ed[$];
      logic [7:0]  etx;
      int n, erst, lim, zeros, bad, k0, t0;
      bit is_load;
      clear_logs();
      n = 0; erst = 0; is_load = 0;
      if (cmd[0] == CMD_LOAD) begin
         is_load = 1;
         n = (cmd[1] == 8'h00) ? 256 : int'(cmd[1]);
         for (int i = 0; i < n; i++) begin
            ea.push_back(8'(i % 256));
            ed.push_back({cmd[4*i+5], cmd[4*i+4], cmd[4*i+3], cmd[4*i+2]});
         end
         etx = ACK;
      end else if (cmd[0] == CMD_RST) begin
         etx = ACK; erst = 1;
      end else begin
         etx = NAK;
      end
      foreach (cmd[i]) rxq.push_back(cmd[i]);
      lim = cmd.size() * 4 + 200;
      for (int k = 0; k < lim && tx_b.size() == 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2;
      check("tx_count", tx_b.size(), 1);
      if (tx_b.size() > 0) begin
         check("tx_byte", tx_b[0], {1'b0, etx});
         check("tx_start_cnt", ts_c.size(), 1);
         if (ts_c.size() > 0) check("tx_start_time", ts_c[0], tx_c[0] + 1);
      end
      check("rx_count", rx_b.size(), cmd.size());
      bad = 0;
      foreach (rx_b[i]) if (i < cmd.size() && rx_b[i] !== cmd[i]) bad++;
      check("rx_bytes", bad, 0);
      check("cpu_rst_cnt", rst_c.size(), erst);
      check("wr_count", w_a.size(), ea.size());
      for (int i = 0; i < w_a.size() && i < ea.size(); i++) begin
         check("wr_addr", w_a[i], ea[i]);
         check("wr_data", w_d[i], ed[i]);
         if (4*i+5 < rx_c.size()) check("wr_time", w_c[i], rx_c[4*i+5] + 1);
      end
      if (is_load) begin
         check("addr_end", bif.o_imem_addr, 8'(n % 256));
         check("wdata_hold", bif.o_imem_wdata, ed[n-1]);
         if (rx_c.size() > 0 && tx_c.size() > 0) begin
            k0 = rx_c[0]; t0 = tx_c[0]; zeros = 0;
            for (int c = k0; c <= t0 + 1 && c < 20000; c++) if (!en_log[c]) zeros++;
            check("cpu_en_low_span", zeros, t0 - k0);
            if (t0 + 1 < 20000) check("cpu_en_restored", en_log[t0+1], 1);
         end
      end
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check_reset_vals("por");
      @(negedge clk) rst = 1'b0;

      // single word
      cmd = '{8'h4C, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
      run_cmd();

      // two words
      cmd = '{8'h4C, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_cmd();

      // reset mid-word: nothing written, outputs back to reset values
      clear_logs();
      rxq.push_back(8'h4C); rxq.push_back(8'h01); rxq.push_back(8'hAA); rxq.push_back(8'hBB);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      check_reset_vals("midload");
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("midload_no_write", w_a.size(), 0);
      cmd = '{8'h4C, 8'h01};
      repeat (4) cmd.push_back(8'($urandom));
      run_cmd();

      // full image with random RX gaps
      stall_en = 1'b1;
      cmd = '{8'h4C, 8'h00};
      repeat (1024) cmd.push_back(8'($urandom));
      run_cmd();

      // unknown commands
      cmd = '{8'h41};
      run_cmd();
      repeat (3) begin
         do b = 8'($urandom); while (b == CMD_LOAD || b == CMD_RST);
         cmd = '{b};
         run_cmd();
      end

      // CPU reset command
      cmd = '{CMD_RST};
      run_cmd();

      // random short loads
      repeat (3) begin
         cmd = '{8'h4C, 8'($urandom_range(1, 6))};
         repeat (4 * int'(cmd[1])) cmd.push_back(8'($urandom));
         run_cmd();
      end

      // TX FIFO full while ACK pending
      stall_en  = 1'b0;
      tx_full_r = 1'b1;
      cmd = '{CMD_RST};
      fork
         run_cmd();
         begin
            repeat (12) @(negedge clk);
            #2;
            check("full_hold_wr", tx_b.size(), 0);
            check("full_hold_rst", rst_c.size(), 1);
            @(negedge clk) tx_full_r = 1'b0;
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
